fifo_core: RTL and testbench

Synchronous FIFO storage and pointer engine sitting directly downstream of the FIFO register block. Consumes its `fifo_enable`, `fifo_clear` and `almost_full_thresh` controls. Produces the empty, full, count, overflow and underflow status the register block samples. Provides a single-clock push/pop data path with registered read data.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_mem.sv | 54 +++++
 rtl/fifo_core.sv | 109 ++++++++++
 tb/tb_fifo_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// Module  : fifo_pkg
// Brief   : Default geometry and pointer/count width helpers for the FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  // Pointer width addresses DEPTH entries; count needs one extra bit to hold DEPTH.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  typedef logic [ptr_width(DEFAULT_DEPTH)-1:0] ptr_t;
  typedef logic [cnt_width(DEFAULT_DEPTH)-1:0] cnt_t;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
//------------------------------------------------------------------------------
// Module  : fifo_mem
// Brief   : DEPTH x WIDTH storage, one synchronous write port, one registered read port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Storage is never reset or cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= r_mem[i_rd_addr];
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule : fifo_mem

`default_nettype wire

// File: rtl/fifo_core.sv
//------------------------------------------------------------------------------
// Module  : fifo_core
// Brief   : Single-clock FIFO pointer engine with occupancy flags and error pulses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_core
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_en,
  input  logic [WIDTH-1:0]              i_wr_data,
  input  logic                          i_rd_en,
  output logic [WIDTH-1:0]              o_rd_data,
  output logic                          o_rd_valid,
  input  logic                          i_fifo_enable,
  input  logic                          i_fifo_clear,
  input  logic [cnt_width(DEPTH)-1:0]   i_almost_full_thresh,
  output logic                          o_fifo_empty,
  output logic                          o_fifo_full,
  output logic                          o_fifo_almost_full,
  output logic [cnt_width(DEPTH)-1:0]   o_fifo_count,
  output logic                          o_fifo_overflow,
  output logic                          o_fifo_underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_go;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic          w_overflow;
  logic          w_underflow;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  // Clear and disable both mask every request, so no pulses fire in those cycles.
  assign w_go        = i_fifo_enable & ~i_fifo_clear & ~rst;
  assign w_pop_ok    = w_go & i_rd_en & ~w_empty;
  assign w_push_ok   = w_go & i_wr_en & (~w_full | w_pop_ok);
  assign w_overflow  = w_go & i_wr_en & ~w_push_ok;
  assign w_underflow = w_go & i_rd_en & w_empty;

  always_ff @(posedge clk) begin
    if (rst || i_fifo_clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_overflow;
      r_underflow <= w_underflow;
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_push_ok),
    .i_wr_addr  (r_wptr),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (w_pop_ok),
    .i_rd_addr  (r_rptr),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid)
  );

  assign o_fifo_empty       = w_empty;
  assign o_fifo_full        = w_full;
  assign o_fifo_almost_full = (r_count >= i_almost_full_thresh);
  assign o_fifo_count       = r_count;
  assign o_fifo_overflow    = r_overflow;
  assign o_fifo_underflow   = r_underflow;

endmodule : fifo_core

`default_nettype wire

// File: tb/tb_fifo_core.sv
//------------------------------------------------------------------------------
// Module  : tb_fifo_core
// Brief   : Self-checking bench for fifo_core against a queue-based reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_core;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_wr_en = 1'b0;
  logic [WIDTH-1:0] i_wr_data = '0;
  logic             i_rd_en = 1'b0;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             i_fifo_enable = 1'b1;
  logic             i_fifo_clear = 1'b0;
  logic [CW-1:0]    i_almost_full_thresh = CW'(4);
  logic             o_fifo_empty;
  logic             o_fifo_full;
  logic             o_fifo_almost_full;
  logic [CW-1:0]    o_fifo_count;
  logic             o_fifo_overflow;
  logic             o_fifo_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rd_data = '0;
  logic             m_valid = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_wr_en              (i_wr_en),
    .i_wr_data            (i_wr_data),
    .i_rd_en              (i_rd_en),
    .o_rd_data            (o_rd_data),
    .o_rd_valid           (o_rd_valid),
    .i_fifo_enable        (i_fifo_enable),
    .i_fifo_clear         (i_fifo_clear),
    .i_almost_full_thresh (i_almost_full_thresh),
    .o_fifo_empty         (o_fifo_empty),
    .o_fifo_full          (o_fifo_full),
    .o_fifo_almost_full   (o_fifo_almost_full),
    .o_fifo_count         (o_fifo_count),
    .o_fifo_overflow      (o_fifo_overflow),
    .o_fifo_underflow     (o_fifo_underflow)
  );

  function automatic logic [CW-1:0] m_count();
    return CW'(q.size());
  endfunction

  // Apply one cycle of requests, advance the model, and settle 1ns past the edge.
  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
    int  sz;
    bit  pop;
    bit  push;
    i_wr_en   = wr;
    i_wr_data = d;
    i_rd_en   = rd;
    sz = q.size();
    if (rst) begin
      q.delete();
      m_rd_data = '0;
      m_valid = 0; m_ovf = 0; m_udf = 0;
    end else if (i_fifo_clear) begin
      q.delete();
      m_valid = 0; m_ovf = 0; m_udf = 0;
    end else if (!i_fifo_enable) begin
      m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      pop   = rd && (sz > 0);
      push  = wr && ((sz < DEPTH) || pop);
      m_ovf = wr && !push;
      m_udf = rd && (sz == 0);
      m_valid = pop;
      if (pop)  m_rd_data = q.pop_front();
      if (push) q.push_back(d);
    end
    @(posedge clk);
    #1;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, '0, 0);
    step(1, 8'h3C, 1);
    rst = 1'b0;
    n_checks++; if (o_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", o_rd_data); end
    n_checks++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", o_rd_valid); end
    n_checks++; if (o_fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_fifo_count); end
    n_checks++; if (o_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", o_fifo_empty); end
    n_checks++; if (o_fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", o_fifo_full); end
    n_checks++; if (o_fifo_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b expected 0", o_fifo_almost_full); end
    n_checks++; if (o_fifo_overflow !== 1'b0 || o_fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got ovf=%b udf=%b expected 0 0", o_fifo_overflow, o_fifo_underflow); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, WIDTH'(i), 0);
      n_checks++; if (o_fifo_count !== CW'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, o_fifo_count, i + 1); end
    end
    n_checks++; if (o_fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", o_fifo_full); end
    step(1, 8'hEE, 0);
    n_checks++; if (o_fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_pulse: got %b expected 1", o_fifo_overflow); end
    n_checks++; if (o_fifo_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL overflow_count: got %0d expected %0d", o_fifo_count, DEPTH); end
    step(0, '0, 0);
    n_checks++; if (o_fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_one_cycle: got %b expected 0", o_fifo_overflow); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1);
      n_checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== WIDTH'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, o_rd_valid, o_rd_data, WIDTH'(i)); end
    end
    n_checks++; if (o_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", o_fifo_empty); end
    step(0, '0, 1);
    n_checks++; if (o_fifo_underflow !== 1'b1 || o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse: got udf=%b v=%b expected 1 0", o_fifo_underflow, o_rd_valid); end
    n_checks++; if (o_rd_data !== 8'h0F) begin n_fail++; $display("FAIL rd_data_hold: got %h expected 0f", o_rd_data); end
    step(0, '0, 0);
    n_checks++; if (o_fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_one_cycle: got %b expected 0", o_fifo_underflow); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    step(1, 8'hA5, 0);
    step(0, '0, 1);
    n_checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA5) begin n_fail++; $display("FAIL latency_a5: got v=%b d=%h expected v=1 d=a5", o_rd_valid, o_rd_data); end
    step(1, WIDTH'($urandom), 0);
    for (int i = 0; i < 40; i++) begin
      d = WIDTH'($urandom);
      step(1, d, 1);
      n_checks++; if (o_fifo_count !== 5'd1 || o_rd_valid !== 1'b1 || o_rd_data !== m_rd_data) begin n_fail++; $display("FAIL b2b[%0d]: got cnt=%0d v=%b d=%h expected cnt=1 v=1 d=%h", i, o_fifo_count, o_rd_valid, o_rd_data, m_rd_data); end
    end
  endtask

  task automatic test_full_simul();
    while (q.size() < DEPTH) step(1, WIDTH'($urandom), 0);
    step(1, 8'h77, 1);
    n_checks++; if (o_fifo_overflow !== 1'b0 || o_fifo_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_simul: got ovf=%b cnt=%0d expected 0 %0d", o_fifo_overflow, o_fifo_count, DEPTH); end
    n_checks++; if (o_rd_data !== m_rd_data) begin n_fail++; $display("FAIL full_simul_data: got %h expected %h", o_rd_data, m_rd_data); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1);
      n_checks++; if (o_rd_data !== m_rd_data || o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL full_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, o_rd_valid, o_rd_data, m_rd_data); end
    end
    n_checks++; if (o_rd_data !== 8'h77) begin n_fail++; $display("FAIL full_last_77: got %h expected 77", o_rd_data); end
  endtask

  task automatic test_clear_disable();
    for (int i = 0; i < 5; i++) step(1, WIDTH'(8'h40 + i), 0);
    i_fifo_clear = 1'b1;
    step(1, 8'h99, 1);
    i_fifo_clear = 1'b0;
    n_checks++; if (o_fifo_count !== '0 || o_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL clear_state: got cnt=%0d empty=%b expected 0 1", o_fifo_count, o_fifo_empty); end
    n_checks++; if (o_fifo_overflow !== 1'b0 || o_fifo_underflow !== 1'b0 || o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_pulses: got ovf=%b udf=%b v=%b expected 0 0 0", o_fifo_overflow, o_fifo_underflow, o_rd_valid); end
    for (int i = 0; i < 3; i++) step(1, WIDTH'(8'h50 + i), 0);
    i_fifo_enable = 1'b0;
    step(1, 8'h66, 1);
    n_checks++; if (o_fifo_count !== 5'd3 || o_rd_valid !== 1'b0 || o_fifo_overflow !== 1'b0 || o_fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL disable_hold: got cnt=%0d v=%b ovf=%b udf=%b expected 3 0 0 0", o_fifo_count, o_rd_valid, o_fifo_overflow, o_fifo_underflow); end
    i_fifo_enable = 1'b1;
    step(0, '0, 1);
    n_checks++; if (o_rd_data !== 8'h50) begin n_fail++; $display("FAIL disable_after: got %h expected 50", o_rd_data); end
  endtask

  task automatic test_thresh();
    i_fifo_clear = 1'b1;
    step(0, '0, 0);
    i_fifo_clear = 1'b0;
    i_almost_full_thresh = CW'(4);
    for (int i = 0; i < 3; i++) step(1, WIDTH'(i), 0);
    n_checks++; if (o_fifo_almost_full !== 1'b0) begin n_fail++; $display("FAIL thresh_3: got %b expected 0", o_fifo_almost_full); end
    step(1, 8'h03, 0);
    n_checks++; if (o_fifo_almost_full !== 1'b1 || o_fifo_count !== 5'd4) begin n_fail++; $display("FAIL thresh_4: got af=%b cnt=%0d expected 1 4", o_fifo_almost_full, o_fifo_count); end
  endtask

  task automatic test_random();
    int wr_bias;
    for (int i = 0; i < 400; i++) begin
      wr_bias = ((i / 50) % 2 == 0) ? 80 : 30;
      i_fifo_enable = ($urandom_range(0, 9) != 0);
      i_fifo_clear  = ($urandom_range(0, 39) == 0);
      rst           = ($urandom_range(0, 149) == 0);
      i_almost_full_thresh = CW'($urandom_range(0, DEPTH));
      step($urandom_range(0, 99) < wr_bias, WIDTH'($urandom), $urandom_range(0, 99) < (110 - wr_bias));
      n_checks++; if (o_fifo_count !== m_count()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, o_fifo_count, m_count()); end
      n_checks++; if (o_rd_valid !== m_valid || o_rd_data !== m_rd_data) begin n_fail++; $display("FAIL rnd_read[%0d]: got v=%b d=%h expected v=%b d=%h", i, o_rd_valid, o_rd_data, m_valid, m_rd_data); end
      n_checks++; if (o_fifo_overflow !== m_ovf || o_fifo_underflow !== m_udf) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got ovf=%b udf=%b expected %b %b", i, o_fifo_overflow, o_fifo_underflow, m_ovf, m_udf); end
      n_checks++; if (o_fifo_empty !== (q.size() == 0) || o_fifo_full !== (q.size() == DEPTH) || o_fifo_almost_full !== (q.size() >= int'(i_almost_full_thresh))) begin n_fail++; $display("FAIL rnd_flags[%0d]: got e=%b f=%b af=%b size=%0d thresh=%0d", i, o_fifo_empty, o_fifo_full, o_fifo_almost_full, q.size(), i_almost_full_thresh); end
    end
    rst = 1'b0;
    i_fifo_clear = 1'b0;
    i_fifo_enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_back_to_back();
    test_full_simul();
    test_clear_disable();
    test_thresh();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_core

`default_nettype wire
